mycpu_mem_stage: RTL and testbench

MEM stage of the 5-stage MIPS pipeline, between EX and WB; owns the EX/MEM and MEM/WB pipeline registers. Issues the data SRAM access (1-cycle read latency) with store byte-enables/lane alignment (sb/sh/sw/swl/swr), and hands WB its bundle plus held load data (rtCont, aluResult, Mode, rdata) for load extraction.

---
 rtl/mycpu_mem_stage.sv | 193 +++++++++++++++++++
 tb/tb_mycpu_mem_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mycpu_mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM and MEM/WB registers, data SRAM issue, load-data hold.
// Optional misaligned-access checking is enabled by defining MYCPU_MEM_ALIGN_CHK_EN.
module mycpu_mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              es_to_ms_valid,
    output logic              ms_allowin,
    input  logic [ADDR_W-1:0] es_pc,
    input  logic [ADDR_W-1:0] es_alu_result,
    input  logic [ADDR_W-1:0] es_rt_value,
    input  logic [5:0]        es_mode,
    input  logic [2:0]        es_store_mode,
    input  logic [4:0]        es_dest,
    input  logic              es_gr_we,
    input  logic              wb_stall,
    output logic              data_sram_en,
    output logic [3:0]        data_sram_wen,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [ADDR_W-1:0] data_sram_wdata,
    input  logic [ADDR_W-1:0] data_sram_rdata,
    output logic              ws_valid,
    output logic [ADDR_W-1:0] ws_pc,
    output logic [ADDR_W-1:0] ws_alu_result,
    output logic [ADDR_W-1:0] ws_rt_value,
    output logic [5:0]        ws_mode,
    output logic [4:0]        ws_dest,
    output logic              ws_gr_we,
    output logic [ADDR_W-1:0] ws_rdata,
    output logic [1:0]        ws_addr_err
);

    logic              ms_valid;
    logic [ADDR_W-1:0] ms_pc;
    logic [ADDR_W-1:0] ms_alu_result;
    logic [ADDR_W-1:0] ms_rt_value;
    logic [5:0]        ms_mode;
    logic [2:0]        ms_store_mode;
    logic [4:0]        ms_dest;
    logic              ms_gr_we;

    logic              rdata_fresh;
    logic [ADDR_W-1:0] rdata_buf;

    logic              ws_allowin;
    logic              ms_fire;
    logic              es_accept;
    logic              is_load;
    logic              is_store;
    logic [1:0]        lane;
    logic [1:0]        access_err;
    logic [3:0]        st_wen;
    logic [ADDR_W-1:0] st_wdata;

    assign ws_allowin = !ws_valid | !wb_stall;
    assign ms_allowin = !ms_valid | ws_allowin;
    assign ms_fire    = ms_valid & ws_allowin & !flush;
    // flush only blocks the accept when it is killing an occupant of MEM
    assign es_accept  = es_to_ms_valid & ms_allowin & !(flush & ms_valid);

    assign is_load  = ms_mode[5];
    assign is_store = ms_store_mode != 3'b000;
    assign lane     = ms_alu_result[1:0];

`ifdef MYCPU_MEM_ALIGN_CHK_EN
    logic adel;
    logic ades;
    logic [1:0] ws_addr_err_q;

    always_comb begin
        adel = is_load & (((ms_mode[3:1] == 3'b001) & lane[0]) |
                          ((ms_mode[3:1] == 3'b010) & (lane != 2'b00)));
        ades = ((ms_store_mode == 3'b010) & lane[0]) |
               ((ms_store_mode == 3'b011) & (lane != 2'b00));
        access_err = {adel, ades};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_addr_err_q <= '0;
        end else if (ms_fire) begin
            ws_addr_err_q <= access_err;
        end
    end

    assign ws_addr_err = ws_addr_err_q;
`else
    assign access_err  = 2'b00;
    assign ws_addr_err = 2'b00;
`endif

    always_comb begin
        st_wen   = '0;
        st_wdata = '0;
        case (ms_store_mode)
            3'b001: begin
                st_wen   = 4'b0001 << lane;
                st_wdata = {4{ms_rt_value[7:0]}};
            end
            3'b010: begin
                st_wen   = lane[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ms_rt_value[15:0]}};
            end
            3'b011: begin
                st_wen   = 4'b1111;
                st_wdata = ms_rt_value;
            end
            3'b100: begin
                case (lane)
                    2'd0:    begin st_wen = 4'b0001; st_wdata = ms_rt_value >> 24; end
                    2'd1:    begin st_wen = 4'b0011; st_wdata = ms_rt_value >> 16; end
                    2'd2:    begin st_wen = 4'b0111; st_wdata = ms_rt_value >> 8;  end
                    default: begin st_wen = 4'b1111; st_wdata = ms_rt_value;       end
                endcase
            end
            3'b101: begin
                case (lane)
                    2'd0:    begin st_wen = 4'b1111; st_wdata = ms_rt_value;       end
                    2'd1:    begin st_wen = 4'b1110; st_wdata = ms_rt_value << 8;  end
                    2'd2:    begin st_wen = 4'b1100; st_wdata = ms_rt_value << 16; end
                    default: begin st_wen = 4'b1000; st_wdata = ms_rt_value << 24; end
                endcase
            end
            default: begin
                st_wen   = '0;
                st_wdata = '0;
            end
        endcase
    end

    assign data_sram_en    = ms_fire & (is_load | is_store) & (access_err == 2'b00);
    assign data_sram_wen   = (ms_fire & is_store & (access_err == 2'b00)) ? st_wen : 4'b0000;
    assign data_sram_addr  = {ms_alu_result[ADDR_W-1:2], 2'b00};
    assign data_sram_wdata = st_wdata;

    // read data arrives the cycle after the request; the buffer keeps it across WB stalls
    assign ws_rdata = rdata_fresh ? data_sram_rdata : rdata_buf;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid      <= 1'b0;
            ms_pc         <= '0;
            ms_alu_result <= '0;
            ms_rt_value   <= '0;
            ms_mode       <= '0;
            ms_store_mode <= '0;
            ms_dest       <= '0;
            ms_gr_we      <= 1'b0;
            ws_valid      <= 1'b0;
            ws_pc         <= '0;
            ws_alu_result <= '0;
            ws_rt_value   <= '0;
            ws_mode       <= '0;
            ws_dest       <= '0;
            ws_gr_we      <= 1'b0;
            rdata_fresh   <= 1'b0;
            rdata_buf     <= '0;
        end else begin
            if (es_accept) begin
                ms_valid      <= 1'b1;
                ms_pc         <= es_pc;
                ms_alu_result <= es_alu_result;
                ms_rt_value   <= es_rt_value;
                ms_mode       <= es_mode;
                ms_store_mode <= es_store_mode;
                ms_dest       <= es_dest;
                ms_gr_we      <= es_gr_we;
            end else if (ms_fire | flush) begin
                ms_valid <= 1'b0;
            end

            if (ms_fire) begin
                ws_valid      <= 1'b1;
                ws_pc         <= ms_pc;
                ws_alu_result <= ms_alu_result;
                ws_rt_value   <= ms_rt_value;
                ws_mode       <= ms_mode;
                ws_dest       <= ms_dest;
                ws_gr_we      <= ms_gr_we & (access_err == 2'b00);
            end else if (ws_allowin) begin
                ws_valid <= 1'b0;
            end

            rdata_fresh <= ms_fire;
            if (rdata_fresh) begin
                rdata_buf <= data_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mycpu_mem_stage.sv
// Self-checking bench for mycpu_mem_stage: directed scenarios plus a randomized run against a
// transaction-level model (two pipeline slots and a byte-lane memory-write view of stores).
module tb_mycpu_mem_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [5:0]  mode;
        logic [2:0]  sm;
        logic [4:0]  dest;
        logic        we;
    } ins_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush = 1'b0;
    logic        es_to_ms_valid = 1'b0;
    logic        ms_allowin;
    logic [31:0] es_pc = '0;
    logic [31:0] es_alu_result = '0;
    logic [31:0] es_rt_value = '0;
    logic [5:0]  es_mode = '0;
    logic [2:0]  es_store_mode = '0;
    logic [4:0]  es_dest = '0;
    logic        es_gr_we = 1'b0;
    logic        wb_stall = 1'b0;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata = '0;
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic [31:0] ws_alu_result;
    logic [31:0] ws_rt_value;
    logic [5:0]  ws_mode;
    logic [4:0]  ws_dest;
    logic        ws_gr_we;
    logic [31:0] ws_rdata;
    logic [1:0]  ws_addr_err;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] LW   = 6'b100100;
    localparam logic [2:0] SB   = 3'd1, SH = 3'd2, SW = 3'd3, SWL = 3'd4, SWR = 3'd5;

    always #5 clk = ~clk;

    mycpu_mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_alu_result(es_alu_result), .es_rt_value(es_rt_value),
        .es_mode(es_mode), .es_store_mode(es_store_mode), .es_dest(es_dest), .es_gr_we(es_gr_we),
        .wb_stall(wb_stall),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_alu_result(ws_alu_result),
        .ws_rt_value(ws_rt_value), .ws_mode(ws_mode), .ws_dest(ws_dest), .ws_gr_we(ws_gr_we),
        .ws_rdata(ws_rdata), .ws_addr_err(ws_addr_err)
    );

    // Memory-write view of a store: which bytes of the word change and to which rt byte.
    function automatic logic [35:0] exp_store(input logic [2:0] sm, input logic [1:0] a, input logic [31:0] rt);
        logic [3:0]  wen = '0;
        logic [31:0] data = '0;
        for (int j = 0; j < 4; j++) begin
            int src = -1;
            case (sm)
                SB:  if (j == a) src = 0;
                SH:  if ((j / 2) == (a / 2)) src = j % 2;
                SW:  src = j;
                SWL: if (j <= a) src = 3 - a + j;
                SWR: if (j >= a) src = j - a;
                default: src = -1;
            endcase
            if (src >= 0) begin
                wen[j] = 1'b1;
                data[j*8 +: 8] = rt[src*8 +: 8];
            end
        end
        return {wen, data};
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] wen);
        return {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    endfunction

    function automatic logic [1:0] exp_err(input ins_t i);
`ifdef MYCPU_MEM_ALIGN_CHK_EN
        logic [1:0] a = i.alu[1:0];
        logic adel = i.mode[5] && ((i.mode[3:1] == 3'd1 && a[0]) || (i.mode[3:1] == 3'd2 && a != 2'd0));
        logic ades = (i.sm == SH && a[0]) || (i.sm == SW && a != 2'd0);
        return {adel, ades};
`else
        return {1'b0, i.alu[0] & 1'b0};
`endif
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; es_to_ms_valid = 1'b0; flush = 1'b0; wb_stall = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic drain();
        es_to_ms_valid = 1'b0; flush = 1'b0; wb_stall = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Offers one instruction to an idle MEM; returns #1 after the next negedge, with it held in MEM.
    task automatic issue(input logic [31:0] pc, alu, rt, input logic [5:0] mode, input logic [2:0] sm);
        @(negedge clk);
        es_to_ms_valid = 1'b1; es_pc = pc; es_alu_result = alu; es_rt_value = rt;
        es_mode = mode; es_store_mode = sm; es_dest = pc[6:2]; es_gr_we = (mode[5] == 1'b1);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", data_sram_en); end
        checks++; if (data_sram_wen !== 4'b0000) begin errors++; $display("FAIL reset_wen got=%b exp=0000", data_sram_wen); end
        checks++; if (ws_valid !== 1'b0) begin errors++; $display("FAIL reset_ws_valid got=%b exp=0", ws_valid); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%b exp=1", ms_allowin); end
        checks++; if (ws_rdata !== 32'h0 || ws_pc !== 32'h0) begin errors++; $display("FAIL reset_ws_regs got rdata=%h pc=%h exp 0", ws_rdata, ws_pc); end
        resetn = 1'b1;
    endtask

    task automatic test_stores();
        issue(32'hBFC00100, 32'h10000004, 32'hDEADBEEF, 6'd0, SW);
        checks++; if ({data_sram_en, data_sram_wen} !== 5'b1_1111) begin errors++; $display("FAIL sw_en_wen got=%b%b exp=1_1111", data_sram_en, data_sram_wen); end
        checks++; if (data_sram_addr !== 32'h10000004) begin errors++; $display("FAIL sw_addr got=%h exp=10000004", data_sram_addr); end
        checks++; if (data_sram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", data_sram_wdata); end
        @(negedge clk); #1;
        checks++; if (ws_valid !== 1'b1 || ws_alu_result !== 32'h10000004) begin errors++; $display("FAIL sw_ws got valid=%b alu=%h exp 1/10000004", ws_valid, ws_alu_result); end
        issue(32'hBFC00104, 32'h10000002, 32'h12345678, 6'd0, SB);
        checks++; if (data_sram_wen !== 4'b0100 || data_sram_wdata !== 32'h78787878) begin errors++; $display("FAIL sb got wen=%b wdata=%h exp 0100/78787878", data_sram_wen, data_sram_wdata); end
        issue(32'hBFC00108, 32'h10000002, 32'h12345678, 6'd0, SH);
        checks++; if (data_sram_wen !== 4'b1100 || data_sram_wdata !== 32'h56785678) begin errors++; $display("FAIL sh got wen=%b wdata=%h exp 1100/56785678", data_sram_wen, data_sram_wdata); end
        issue(32'hBFC0010C, 32'h10000001, 32'hAABBCCDD, 6'd0, SWL);
        checks++; if (data_sram_wen !== 4'b0011 || data_sram_wdata !== 32'h0000AABB) begin errors++; $display("FAIL swl got wen=%b wdata=%h exp 0011/0000aabb", data_sram_wen, data_sram_wdata); end
        issue(32'hBFC00110, 32'h10000002, 32'hAABBCCDD, 6'd0, SWR);
        checks++; if (data_sram_wen !== 4'b1100 || data_sram_wdata !== 32'hCCDD0000) begin errors++; $display("FAIL swr got wen=%b wdata=%h exp 1100/ccdd0000", data_sram_wen, data_sram_wdata); end
        drain();
    endtask

    task automatic test_load_stall();
        issue(32'hBFC00200, 32'h10000040, 32'h0, LW, 3'd0);
        checks++; if (data_sram_en !== 1'b1 || data_sram_wen !== 4'b0000) begin errors++; $display("FAIL lw_issue got en=%b wen=%b exp 1/0000", data_sram_en, data_sram_wen); end
        @(negedge clk);
        data_sram_rdata = 32'h11223344; wb_stall = 1'b1;
        es_to_ms_valid = 1'b1; es_pc = 32'hBFC00204; es_alu_result = 32'h10000080; es_mode = LW; es_store_mode = 3'd0;
        #1;
        checks++; if (ws_valid !== 1'b1 || ws_rdata !== 32'h11223344) begin errors++; $display("FAIL lw_fresh got valid=%b rdata=%h exp 1/11223344", ws_valid, ws_rdata); end
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL lw_stall_a_en got=%b exp=0", data_sram_en); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            es_to_ms_valid = 1'b0; data_sram_rdata = $urandom | 32'h1;
            #1;
            checks++; if (ws_rdata !== 32'h11223344) begin errors++; $display("FAIL lw_hold got=%h exp=11223344", ws_rdata); end
            checks++; if (ms_allowin !== 1'b0 || data_sram_en !== 1'b0) begin errors++; $display("FAIL lw_stall_busy got allowin=%b en=%b exp 0/0", ms_allowin, data_sram_en); end
        end
        @(negedge clk);
        wb_stall = 1'b0; data_sram_rdata = 32'h0BAD0BAD;
        #1;
        checks++; if (ws_rdata !== 32'h11223344 || data_sram_en !== 1'b1) begin errors++; $display("FAIL lw_release got rdata=%h en=%b exp 11223344/1", ws_rdata, data_sram_en); end
        drain();
    endtask

    task automatic test_flush_and_reset();
        issue(32'hBFC00300, 32'h10000008, 32'hCAFEF00D, 6'd0, SW);
        flush = 1'b1;
        #1;
        checks++; if (data_sram_en !== 1'b0 || data_sram_wen !== 4'b0000) begin errors++; $display("FAIL flush_kill got en=%b wen=%b exp 0/0000", data_sram_en, data_sram_wen); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (ws_valid !== 1'b0 || data_sram_en !== 1'b0 || ms_allowin !== 1'b1) begin errors++; $display("FAIL flush_after got ws_valid=%b en=%b allowin=%b exp 0/0/1", ws_valid, data_sram_en, ms_allowin); end
        issue(32'hBFC00310, 32'h10000010, 32'h0, LW, 3'd0);
        es_to_ms_valid = 1'b1; es_pc = 32'hBFC00314; es_alu_result = 32'h10000014; es_mode = LW; es_store_mode = 3'd0;
        @(negedge clk);
        es_to_ms_valid = 1'b0; resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        checks++; if (ws_valid !== 1'b0 || data_sram_en !== 1'b0 || ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_mid got ws_valid=%b en=%b allowin=%b exp 0/0/1", ws_valid, data_sram_en, ms_allowin); end
        drain();
    endtask

    task automatic test_align();
        issue(32'hBFC00400, 32'h10000002, 32'h0, LW, 3'd0);
`ifdef MYCPU_MEM_ALIGN_CHK_EN
        checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL adel_en got=%b exp=0", data_sram_en); end
        @(negedge clk); #1;
        checks++; if (ws_addr_err !== 2'b10 || ws_gr_we !== 1'b0 || ws_valid !== 1'b1) begin errors++; $display("FAIL adel_ws got err=%b we=%b valid=%b exp 10/0/1", ws_addr_err, ws_gr_we, ws_valid); end
        issue(32'hBFC00404, 32'h10000001, 32'h0, 6'd0, SH);
        checks++; if (data_sram_en !== 1'b0 || data_sram_wen !== 4'b0000) begin errors++; $display("FAIL ades_en got en=%b wen=%b exp 0/0000", data_sram_en, data_sram_wen); end
        @(negedge clk); #1;
        checks++; if (ws_addr_err !== 2'b01) begin errors++; $display("FAIL ades_ws got=%b exp=01", ws_addr_err); end
`else
        checks++; if (data_sram_en !== 1'b1 || data_sram_addr !== 32'h10000000) begin errors++; $display("FAIL noalign_en got en=%b addr=%h exp 1/10000000", data_sram_en, data_sram_addr); end
        @(negedge clk); #1;
        checks++; if (ws_addr_err !== 2'b00 || ws_gr_we !== 1'b1) begin errors++; $display("FAIL noalign_ws got err=%b we=%b exp 00/1", ws_addr_err, ws_gr_we); end
`endif
        drain();
    endtask

    task automatic test_random();
        ins_t mms, mws, nin;
        logic mms_v = 1'b0, mws_v = 1'b0;
        logic pend_fresh = 1'b0;
        logic [31:0] pend_addr = '0;
        logic ws_ok, ms_ok, fire, accept, exp_en;
        logic [35:0] st;
        logic [3:0] exp_wen;
        mms = '0; mws = '0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            nin.pc = $urandom & 32'hFFFF_FFFC;
            nin.alu = {4'h1, 28'($urandom)};
            nin.rt = $urandom;
            nin.dest = 5'($urandom);
            nin.we = 1'($urandom);
            nin.mode = '0; nin.sm = '0;
            case ($urandom_range(0, 2))
                0: nin.mode = {1'b1, 1'b0, 3'($urandom_range(0, 4)), 1'($urandom)};
                1: nin.sm = 3'($urandom_range(1, 5));
                default: ;
            endcase
            es_to_ms_valid = ($urandom_range(0, 3) != 0);
            es_pc = nin.pc; es_alu_result = nin.alu; es_rt_value = nin.rt;
            es_mode = nin.mode; es_store_mode = nin.sm; es_dest = nin.dest; es_gr_we = nin.we;
            wb_stall = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 15) == 0);
            data_sram_rdata = pend_fresh ? mem_word(pend_addr) : $urandom;
            #1;
            ws_ok  = !mws_v || !wb_stall;
            ms_ok  = !mms_v || ws_ok;
            fire   = mms_v && ws_ok && !flush;
            accept = es_to_ms_valid && ms_ok && !(flush && mms_v);
            exp_en = fire && (mms.mode[5] || mms.sm != 0) && exp_err(mms) == 2'b00;
            st = exp_store(mms.sm, mms.alu[1:0], mms.rt);
            exp_wen = (fire && exp_err(mms) == 2'b00) ? st[35:32] : 4'b0000;
            checks++; if (ms_allowin !== ms_ok) begin errors++; $display("FAIL rnd_allowin cyc=%0d got=%b exp=%b", cyc, ms_allowin, ms_ok); end
            checks++; if (data_sram_en !== exp_en || data_sram_wen !== exp_wen) begin errors++; $display("FAIL rnd_sram cyc=%0d got en=%b wen=%b exp en=%b wen=%b", cyc, data_sram_en, data_sram_wen, exp_en, exp_wen); end
            if (exp_en) begin
                checks++; if (data_sram_addr !== {mms.alu[31:2], 2'b00} || ((data_sram_wdata ^ st[31:0]) & lane_mask(exp_wen)) != 32'h0) begin errors++; $display("FAIL rnd_addr_data cyc=%0d got addr=%h wdata=%h exp addr=%h lanes=%h", cyc, data_sram_addr, data_sram_wdata, {mms.alu[31:2], 2'b00}, st[31:0]); end
            end
            checks++; if (ws_valid !== mws_v) begin errors++; $display("FAIL rnd_ws_valid cyc=%0d got=%b exp=%b", cyc, ws_valid, mws_v); end
            if (mws_v) begin
                checks++; if ({ws_pc, ws_alu_result, ws_rt_value, ws_mode, ws_dest, ws_gr_we, ws_addr_err} !== {mws.pc, mws.alu, mws.rt, mws.mode, mws.dest, mws.we && exp_err(mws) == 2'b00, exp_err(mws)}) begin errors++; $display("FAIL rnd_ws_bundle cyc=%0d got pc=%h alu=%h dest=%0d we=%b err=%b exp pc=%h alu=%h dest=%0d", cyc, ws_pc, ws_alu_result, ws_dest, ws_gr_we, ws_addr_err, mws.pc, mws.alu, mws.dest); end
                if (mws.mode[5] && exp_err(mws) == 2'b00) begin
                    checks++; if (ws_rdata !== mem_word({mws.alu[31:2], 2'b00})) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, ws_rdata, mem_word({mws.alu[31:2], 2'b00})); end
                end
            end
            pend_fresh = fire;
            pend_addr = {mms.alu[31:2], 2'b00};
            if (fire) begin mws = mms; mws_v = 1'b1; end
            else if (ws_ok) mws_v = 1'b0;
            if (accept) begin mms = nin; mms_v = 1'b1; end
            else if (fire || flush) mms_v = 1'b0;
        end
        drain();
    endtask

    initial begin
        do_reset();
        test_reset();
        test_stores();
        test_load_stall();
        test_flush_and_reset();
        test_align();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
